// File: rtl/pc_unit_if.sv
// Fetch-control bundle between the pipeline control side (master) and the
// program-counter unit (slave).
interface pc_unit_if #(
  parameter int unsigned WIDTH = 16
);
  logic             hit;
  logic             stall;
  logic             redirect;
  logic [WIDTH-1:0] redirectAddr;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] currentInst;
  logic             pendValid;
  logic             rasEmpty;
  logic             rasFull;

  modport master (
    output hit, stall, redirect, redirectAddr, call, ret,
    input  currentInst, pendValid, rasEmpty, rasFull
  );

  modport slave (
    input  hit, stall, redirect, redirectAddr, call, ret,
    output currentInst, pendValid, rasEmpty, rasFull
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter for the MIPS fetch stage with buffered redirects.
// Define PC_RAS_EN to build the optional circular return-address stack.
module pc_unit #(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int unsigned      INC       = 1,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input logic      clk,
  input logic      rst,
  pc_unit_if.slave bus
);
  localparam logic [WIDTH-1:0] IncVal = WIDTH'(INC);

  logic             adv;
  logic [WIDTH-1:0] seqAddr;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pendValid_q, pendValid_d;
  logic             retTake;
  logic [WIDTH-1:0] rasTop;
  logic             rasEmpty;
  logic             rasFull;

  assign adv     = bus.hit & ~bus.stall;
  assign seqAddr = pc_q + IncVal;

`ifdef PC_RAS_EN
  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [PtrW-1:0]  topIdx;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // ptr_q is the next free slot; once full it also points at the oldest entry
  assign topIdx   = ptr_q - 1'b1;
  assign rasTop   = ras_q[topIdx];
  assign rasEmpty = (cnt_q == '0);
  assign rasFull  = (cnt_q == CntW'(RAS_DEPTH));
  assign retTake  = adv & bus.ret & ~bus.redirect & ~pendValid_q & ~rasEmpty;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (adv) begin
      unique case ({bus.call, retTake})
        2'b10: begin
          ptr_d = ptr_q + 1'b1;
          cnt_d = rasFull ? cnt_q : cnt_q + 1'b1;
        end
        2'b01: begin
          ptr_d = topIdx;
          cnt_d = cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // call+ret replaces the top entry in place, so the write lands on topIdx
  always_ff @(posedge clk) begin
    if (adv && bus.call) begin
      ras_q[retTake ? topIdx : ptr_q] <= seqAddr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
`else
  assign rasTop   = '0;
  assign rasEmpty = 1'b1;
  assign rasFull  = 1'b0;
  assign retTake  = 1'b0;
`endif

  always_comb begin
    pc_d        = pc_q;
    pend_d      = pend_q;
    pendValid_d = pendValid_q;
    if (adv) begin
      if (bus.redirect) begin
        pc_d        = bus.redirectAddr;
        pendValid_d = 1'b0;
      end else if (pendValid_q) begin
        pc_d        = pend_q;
        pendValid_d = 1'b0;
      end else if (retTake) begin
        pc_d = rasTop;
      end else begin
        pc_d = seqAddr;
      end
    end else if (bus.redirect) begin
      pend_d      = bus.redirectAddr;
      pendValid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_VEC;
      pend_q      <= '0;
      pendValid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pendValid_q <= pendValid_d;
    end
  end

  assign bus.currentInst = pc_q;
  assign bus.pendValid   = pendValid_q;
  assign bus.rasEmpty    = rasEmpty;
  assign bus.rasFull     = rasFull;
endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit: a default 16-bit instance plus an
// 8-bit INC=4 instance for wrap-around. RAS cases run when PC_RAS_EN is defined.
module tb_pc_unit;
  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;

  pc_unit_if #(.WIDTH(16)) a ();
  pc_unit_if #(.WIDTH(8))  b ();

  pc_unit dutA (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  pc_unit #(.WIDTH(8), .RESET_VEC(8'h00), .INC(4), .RAS_DEPTH(4)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drives one cycle of inputs on the 16-bit instance, then lets the edge pass
  task automatic applyStimulus(input logic hit, input logic stall, input logic redirect,
                               input logic [15:0] addr, input logic call, input logic ret);
    a.hit          = hit;
    a.stall        = stall;
    a.redirect     = redirect;
    a.redirectAddr = addr;
    a.call         = call;
    a.ret          = ret;
    tick();
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst = 1'b1;
    a.hit = 1'b0; a.stall = 1'b0; a.redirect = 1'b0; a.redirectAddr = '0;
    a.call = 1'b0; a.ret = 1'b0;
    b.hit = 1'b0; b.stall = 1'b0; b.redirect = 1'b0; b.redirectAddr = '0;
    b.call = 1'b0; b.ret = 1'b0;

    tick();
    tick();
    checkOutput("reset pc", a.currentInst, 32'h0);
    checkOutput("reset pendValid", a.pendValid, 32'h0);
    checkOutput("reset rasEmpty", a.rasEmpty, 32'h1);
    checkOutput("reset rasFull", a.rasFull, 32'h0);
    checkOutput("reset pc B", b.currentInst, 32'h0);

    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1, 0, 0, 16'h0, 0, 0);
      checkOutput("seq advance", a.currentInst, 32'(i));
    end

    rst = 1'b1;
    applyStimulus(1, 0, 0, 16'h0, 0, 0);
    checkOutput("mid-run reset", a.currentInst, 32'h0);
    rst = 1'b0;

    applyStimulus(1, 0, 1, 16'h0005, 0, 0);
    checkOutput("redirect to 5", a.currentInst, 32'h5);

    applyStimulus(0, 0, 1, 16'h0040, 0, 0);
    checkOutput("miss hold 1", a.currentInst, 32'h5);
    checkOutput("miss pendValid 1", a.pendValid, 32'h1);
    applyStimulus(0, 0, 1, 16'h0080, 0, 0);
    checkOutput("miss hold 2", a.currentInst, 32'h5);
    applyStimulus(0, 0, 0, 16'h0000, 0, 0);
    checkOutput("miss hold 3", a.currentInst, 32'h5);
    checkOutput("miss pendValid 3", a.pendValid, 32'h1);
    applyStimulus(1, 0, 0, 16'h0000, 0, 0);
    checkOutput("pending applied", a.currentInst, 32'h80);
    checkOutput("pending cleared", a.pendValid, 32'h0);

    applyStimulus(1, 1, 1, 16'h0080, 0, 0);
    checkOutput("stall hold", a.currentInst, 32'h80);
    checkOutput("stall pendValid", a.pendValid, 32'h1);
    applyStimulus(1, 0, 1, 16'h0020, 0, 0);
    checkOutput("redirect beats pending", a.currentInst, 32'h20);
    checkOutput("pending discarded", a.pendValid, 32'h0);
    applyStimulus(1, 0, 0, 16'h0000, 0, 0);
    checkOutput("after discard", a.currentInst, 32'h21);
    applyStimulus(1, 1, 0, 16'h0000, 0, 0);
    checkOutput("stall no redirect", a.currentInst, 32'h21);

    applyStimulus(0, 0, 1, 16'h0099, 0, 0);
    rst = 1'b1;
    applyStimulus(1, 0, 0, 16'h0000, 0, 0);
    checkOutput("reset beats pending pc", a.currentInst, 32'h0);
    checkOutput("reset beats pending pv", a.pendValid, 32'h0);
    rst = 1'b0;
    applyStimulus(1, 0, 0, 16'h0000, 0, 0);
    checkOutput("post-reset advance", a.currentInst, 32'h1);

    applyStimulus(1, 0, 1, 16'h0007, 0, 0);
    applyStimulus(1, 0, 0, 16'h0000, 0, 1);
    checkOutput("ret on empty ras", a.currentInst, 32'h8);

`ifdef PC_RAS_EN
    applyStimulus(1, 0, 1, 16'h0010, 0, 0);
    applyStimulus(1, 0, 1, 16'h0100, 1, 0);
    checkOutput("call target", a.currentInst, 32'h100);
    checkOutput("call rasEmpty", a.rasEmpty, 32'h0);
    applyStimulus(1, 0, 0, 16'h0000, 0, 0);
    applyStimulus(1, 0, 0, 16'h0000, 0, 1);
    checkOutput("return addr", a.currentInst, 32'h11);
    checkOutput("return rasEmpty", a.rasEmpty, 32'h1);

    // pushes 0x12, 0x201, 0x301, 0x401, 0x501; the fifth evicts 0x12
    for (int i = 2; i <= 6; i++) begin
      applyStimulus(1, 0, 1, 16'(i * 16'h100), 1, 0);
    end
    checkOutput("ras full", a.rasFull, 32'h1);
    checkOutput("pc after pushes", a.currentInst, 32'h600);
    for (int i = 5; i >= 2; i--) begin
      applyStimulus(1, 0, 0, 16'h0000, 0, 1);
      checkOutput("lifo pop", a.currentInst, 32'(i * 16'h100 + 1));
    end
    checkOutput("drained rasEmpty", a.rasEmpty, 32'h1);
    applyStimulus(1, 0, 0, 16'h0000, 0, 1);
    checkOutput("fifth ret sequential", a.currentInst, 32'h202);

    applyStimulus(1, 0, 1, 16'h0700, 1, 0);
    applyStimulus(1, 0, 0, 16'h0000, 1, 1);
    checkOutput("call+ret pc", a.currentInst, 32'h203);
    checkOutput("call+ret not empty", a.rasEmpty, 32'h0);
    applyStimulus(1, 0, 0, 16'h0000, 0, 1);
    checkOutput("call+ret replaced top", a.currentInst, 32'h701);
    checkOutput("call+ret count", a.rasEmpty, 32'h1);

    applyStimulus(1, 0, 1, 16'h0800, 1, 0);
    applyStimulus(1, 0, 1, 16'h0900, 0, 1);
    checkOutput("redirect beats ret", a.currentInst, 32'h900);
    checkOutput("ret not consumed", a.rasEmpty, 32'h0);
    applyStimulus(1, 0, 0, 16'h0000, 0, 1);
    checkOutput("deferred ret", a.currentInst, 32'h702);

    applyStimulus(0, 0, 0, 16'h0000, 1, 0);
    checkOutput("frozen call ignored", a.rasEmpty, 32'h1);
`else
    applyStimulus(1, 0, 1, 16'h0100, 1, 0);
    checkOutput("no-ras call target", a.currentInst, 32'h100);
    checkOutput("no-ras rasEmpty", a.rasEmpty, 32'h1);
    applyStimulus(1, 0, 0, 16'h0000, 0, 1);
    checkOutput("no-ras ret sequential", a.currentInst, 32'h101);
    checkOutput("no-ras rasFull", a.rasFull, 32'h0);
`endif

    applyStimulus(0, 0, 0, 16'h0000, 0, 0);
    b.hit = 1'b1; b.redirect = 1'b1; b.redirectAddr = 8'hFC;
    tick();
    checkOutput("B redirect FC", b.currentInst, 32'hFC);
    b.redirect = 1'b0;
    tick();
    checkOutput("B wrap", b.currentInst, 32'h00);
    tick();
    checkOutput("B after wrap", b.currentInst, 32'h04);
    b.hit = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
